// File: rtl/parking_gate_ctrl_pkg.sv
// Shared types and BCD helpers for the parking gate controller.
// The states and grant constants are shared by the controller and its checkers.
package parking_gate_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_OPEN_ENT = 2'd1,
    ST_OPEN_SAL = 2'd2
  } gate_state_e;

  typedef enum logic {
    GNT_SAL = 1'b0,
    GNT_ENT = 1'b1
  } grant_e;

  typedef struct packed {
    logic [3:0] tens;
    logic [3:0] units;
  } bcd_t;

  function automatic bcd_t bcd_inc(input bcd_t v);
    bcd_t r;
    r = v;
    if (v.units == 4'd9) begin
      r.units = 4'd0;
      r.tens  = v.tens + 4'd1;
    end else begin
      r.units = v.units + 4'd1;
    end
    return r;
  endfunction

  function automatic bcd_t bcd_dec(input bcd_t v);
    bcd_t r;
    r = v;
    if (v.units == 4'd0) begin
      r.units = 4'd9;
      r.tens  = v.tens - 4'd1;
    end else begin
      r.units = v.units - 4'd1;
    end
    return r;
  endfunction

endpackage

// File: rtl/parking_gate_ctrl_req_latch.sv
// Request front end: normalises polarity, samples, detects the asserting edge
// and holds a single pending flag whose set wins over a same-cycle clear.
module parking_gate_ctrl_req_latch #(
  parameter int ACT_LOW = 1
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic req_i,
  input  logic clr_i,
  output logic pend_o
);

  logic req_norm_s;
  logic event_s;
  logic pend_d;
  logic req_s_q;
  logic req_d_q;
  logic pend_q;

  assign req_norm_s = (ACT_LOW != 0) ? ~req_i : req_i;
  assign event_s    = req_s_q & ~req_d_q;
  assign pend_d     = event_s | (pend_q & ~clr_i);

  // Sample, edge history and pending flag
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      req_s_q <= 1'b0;
      req_d_q <= 1'b0;
      pend_q  <= 1'b0;
    end else begin
      req_s_q <= req_norm_s;
      req_d_q <= req_s_q;
      pend_q  <= pend_d;
    end
  end

  assign pend_o = pend_q;

endmodule

// File: rtl/parking_gate_ctrl.sv
// Parking occupancy controller: arbitrates entry/exit requests round-robin onto one
// counter, opens the matching barrier for a timed window and tracks the count in BCD.
module parking_gate_ctrl
  import parking_gate_ctrl_pkg::*;
#(
  parameter int CAPACITY   = 20,
  parameter int GATE_TICKS = 2000,
  parameter int ACT_LOW    = 1,
  parameter int CNT_W      = 7
) (
  input  logic             clk_slow,
  input  logic             rst_n,
  input  logic             ent_req,
  input  logic             sal_req,
  output logic [CNT_W-1:0] count,
  output logic [3:0]       bcd_tens,
  output logic [3:0]       bcd_units,
  output logic             barrera_ent,
  output logic             barrera_sal,
  output logic             lleno,
  output logic             vacio,
  output logic             rechazo
);

  localparam int              TMR_W    = $clog2(GATE_TICKS + 1);
  localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(GATE_TICKS - 1);

  logic             pend_ent_s, pend_sal_s;
  logic             grant_ent_s, grant_sal_s;
  logic             inc_s, dec_s;
  logic [CNT_W-1:0] count_d;
  bcd_t             bcd_d;

  gate_state_e      state_q;
  grant_e           last_grant_q;
  logic [TMR_W-1:0] timer_q;
  logic [CNT_W-1:0] count_q;
  bcd_t             bcd_q;
  logic             barrera_ent_q, barrera_sal_q, lleno_q, vacio_q, rechazo_q;

  parking_gate_ctrl_req_latch #(.ACT_LOW(ACT_LOW)) u_ent (
    .clk_i   (clk_slow),
    .rst_n_i (rst_n),
    .req_i   (ent_req),
    .clr_i   (grant_ent_s),
    .pend_o  (pend_ent_s)
  );

  parking_gate_ctrl_req_latch #(.ACT_LOW(ACT_LOW)) u_sal (
    .clk_i   (clk_slow),
    .rst_n_i (rst_n),
    .req_i   (sal_req),
    .clr_i   (grant_sal_s),
    .pend_o  (pend_sal_s)
  );

  // Grant selection (ties go to the side not served last) and next count/BCD
  always_comb begin
    grant_ent_s = 1'b0;
    grant_sal_s = 1'b0;
    if (state_q == ST_IDLE) begin
      if (pend_ent_s && (!pend_sal_s || (last_grant_q == GNT_SAL))) begin
        grant_ent_s = 1'b1;
      end else if (pend_sal_s) begin
        grant_sal_s = 1'b1;
      end else begin
        grant_ent_s = 1'b0;
      end
    end else begin
      grant_sal_s = 1'b0;
    end
    inc_s   = grant_ent_s & ~lleno_q;
    dec_s   = grant_sal_s & ~vacio_q;
    count_d = count_q;
    bcd_d   = bcd_q;
    if (inc_s) begin
      count_d = count_q + CNT_W'(1);
      bcd_d   = bcd_inc(bcd_q);
    end else if (dec_s) begin
      count_d = count_q - CNT_W'(1);
      bcd_d   = bcd_dec(bcd_q);
    end else begin
      count_d = count_q;
    end
  end

  // Gate FSM with registered count, flags and barrier outputs
  always_ff @(posedge clk_slow) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      last_grant_q  <= GNT_SAL;
      timer_q       <= '0;
      count_q       <= '0;
      bcd_q         <= '0;
      barrera_ent_q <= 1'b0;
      barrera_sal_q <= 1'b0;
      lleno_q       <= 1'b0;
      vacio_q       <= 1'b1;
      rechazo_q     <= 1'b0;
    end else begin
      count_q   <= count_d;
      bcd_q     <= bcd_d;
      lleno_q   <= (count_d == CNT_W'(CAPACITY));
      vacio_q   <= (count_d == CNT_W'(0));
      rechazo_q <= (grant_ent_s & lleno_q) | (grant_sal_s & vacio_q);
      case (state_q)
        ST_IDLE: begin
          if (inc_s) begin
            state_q       <= ST_OPEN_ENT;
            last_grant_q  <= GNT_ENT;
            timer_q       <= TMR_LOAD;
            barrera_ent_q <= 1'b1;
          end else if (dec_s) begin
            state_q       <= ST_OPEN_SAL;
            last_grant_q  <= GNT_SAL;
            timer_q       <= TMR_LOAD;
            barrera_sal_q <= 1'b1;
          end else begin
            barrera_ent_q <= 1'b0;
            barrera_sal_q <= 1'b0;
          end
        end
        ST_OPEN_ENT, ST_OPEN_SAL: begin
          if (timer_q == TMR_W'(0)) begin
            state_q       <= ST_IDLE;
            barrera_ent_q <= 1'b0;
            barrera_sal_q <= 1'b0;
          end else begin
            timer_q <= timer_q - TMR_W'(1);
          end
        end
        default: begin
          state_q       <= ST_IDLE;
          barrera_ent_q <= 1'b0;
          barrera_sal_q <= 1'b0;
        end
      endcase
    end
  end

  assign count       = count_q;
  assign bcd_tens    = bcd_q.tens;
  assign bcd_units   = bcd_q.units;
  assign barrera_ent = barrera_ent_q;
  assign barrera_sal = barrera_sal_q;
  assign lleno       = lleno_q;
  assign vacio       = vacio_q;
  assign rechazo     = rechazo_q;

endmodule

// File: tb/tb_parking_gate_ctrl.sv
// Bench for parking_gate_ctrl: two instances (capacity 3 and 15) checked against
// an event-level occupancy model, plus directed scenario checks.
module tb_parking_gate_ctrl;

  localparam int GT = 4;
  localparam int CW = 7;

  logic clk = 1'b0;
  logic rst_n;
  logic ent_a, sal_a, ent_b, sal_b;
  logic [CW-1:0] cnt_a, cnt_b;
  logic [3:0] ten_a, uni_a, ten_b, uni_b;
  logic be_a, bs_a, ll_a, va_a, rj_a;
  logic be_b, bs_b, ll_b, va_b, rj_b;

  always #5 clk = ~clk;

  parking_gate_ctrl #(.CAPACITY(3), .GATE_TICKS(GT), .ACT_LOW(1), .CNT_W(CW)) dut_a (
    .clk_slow(clk), .rst_n(rst_n), .ent_req(ent_a), .sal_req(sal_a),
    .count(cnt_a), .bcd_tens(ten_a), .bcd_units(uni_a),
    .barrera_ent(be_a), .barrera_sal(bs_a), .lleno(ll_a), .vacio(va_a), .rechazo(rj_a));

  parking_gate_ctrl #(.CAPACITY(15), .GATE_TICKS(GT), .ACT_LOW(1), .CNT_W(CW)) dut_b (
    .clk_slow(clk), .rst_n(rst_n), .ent_req(ent_b), .sal_req(sal_b),
    .count(cnt_b), .bcd_tens(ten_b), .bcd_units(uni_b),
    .barrera_ent(be_b), .barrera_sal(bs_b), .lleno(ll_b), .vacio(va_b), .rechazo(rj_b));

  // Reference model: occupancy, remaining open ticks, which side is open (1 ent, 2 sal)
  int cap_m [2] = '{3, 15};
  int cnt_m [2];
  int gate_m[2];
  int side_m[2];
  int last_m[2];
  bit rej_m [2];
  bit s_e[2], d_e[2], s_s[2], d_s[2], pe[2], ps[2];

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  function automatic void model_step(int i, bit rst, bit ent, bit sal);
    bit ev_e, ev_s, take_e, take_s;
    if (!rst) begin
      cnt_m[i] = 0; gate_m[i] = 0; side_m[i] = 0; last_m[i] = 0; rej_m[i] = 1'b0;
      s_e[i] = 1'b0; d_e[i] = 1'b0; s_s[i] = 1'b0; d_s[i] = 1'b0; pe[i] = 1'b0; ps[i] = 1'b0;
      return;
    end
    ev_e = s_e[i] & ~d_e[i];
    ev_s = s_s[i] & ~d_s[i];
    take_e = 1'b0; take_s = 1'b0; rej_m[i] = 1'b0;
    if (gate_m[i] == 0) begin
      if (pe[i] && ps[i]) begin
        if (last_m[i] == 0) take_e = 1'b1; else take_s = 1'b1;
      end else if (pe[i]) take_e = 1'b1;
      else if (ps[i]) take_s = 1'b1;
      if (take_e) begin
        if (cnt_m[i] == cap_m[i]) rej_m[i] = 1'b1;
        else begin cnt_m[i]++; gate_m[i] = GT; side_m[i] = 1; last_m[i] = 1; end
      end
      if (take_s) begin
        if (cnt_m[i] == 0) rej_m[i] = 1'b1;
        else begin cnt_m[i]--; gate_m[i] = GT; side_m[i] = 2; last_m[i] = 0; end
      end
    end else begin
      gate_m[i]--;
    end
    pe[i] = ev_e | (pe[i] & ~take_e);
    ps[i] = ev_s | (ps[i] & ~take_s);
    d_e[i] = s_e[i]; s_e[i] = ~ent;
    d_s[i] = s_s[i]; s_s[i] = ~sal;
  endfunction

  function automatic logic [19:0] exp_one(int i);
    logic [19:0] v;
    v = {CW'(cnt_m[i]), 4'(cnt_m[i] / 10), 4'(cnt_m[i] % 10),
         (gate_m[i] > 0 && side_m[i] == 1), (gate_m[i] > 0 && side_m[i] == 2),
         (cnt_m[i] == cap_m[i]), (cnt_m[i] == 0), rej_m[i]};
    return v;
  endfunction

  function automatic logic [39:0] exp_all();
    return {exp_one(0), exp_one(1)};
  endfunction

  function automatic logic [39:0] obs_all();
    return {cnt_a, ten_a, uni_a, be_a, bs_a, ll_a, va_a, rj_a,
            cnt_b, ten_b, uni_b, be_b, bs_b, ll_b, va_b, rj_b};
  endfunction

  task automatic tick();
    @(posedge clk);
    model_step(0, rst_n, ent_a, sal_a);
    model_step(1, rst_n, ent_b, sal_b);
    cyc++;
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; ent_a = 1'b1; sal_a = 1'b1; ent_b = 1'b1; sal_b = 1'b1;
    repeat (2) tick();
    n_checks++;
    if ({cnt_a, ten_a, uni_a, be_a, bs_a, ll_a, va_a, rj_a} !==
        {7'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0}) begin
      $display("FAIL reset_state got=%h required=%h",
               {cnt_a, ten_a, uni_a, be_a, bs_a, ll_a, va_a, rj_a}, 20'h00002);
    end else n_pass++;
    n_checks++;
    if (obs_all() !== exp_all()) $display("FAIL reset_model got=%h required=%h", obs_all(), exp_all());
    else n_pass++;
  endtask

  task automatic test_single_entry();
    int first_hi, hi_n;
    first_hi = -1; hi_n = 0;
    rst_n = 1'b1;
    repeat (2) tick();
    ent_a = 1'b0;
    for (int i = 1; i <= 14; i++) begin
      tick();
      n_checks++;
      if (obs_all() !== exp_all()) $display("FAIL single_model cyc=%0d got=%h required=%h", cyc, obs_all(), exp_all());
      else n_pass++;
      if (be_a === 1'b1) begin
        hi_n++;
        if (first_hi < 0) first_hi = i;
      end
      if (i == 10) ent_a = 1'b1;
    end
    n_checks++;
    if (first_hi !== 3) $display("FAIL single_open_delay got=%0d required=3", first_hi); else n_pass++;
    n_checks++;
    if (hi_n !== GT) $display("FAIL single_open_len got=%0d required=%0d", hi_n, GT); else n_pass++;
    n_checks++;
    if ({cnt_a, ten_a, uni_a} !== {7'd1, 4'd0, 4'd1})
      $display("FAIL single_count got=%0d/%0d/%0d required=1/0/1", cnt_a, ten_a, uni_a);
    else n_pass++;
  endtask

  task automatic test_fill_and_refuse();
    int rej_n, be_last;
    rej_n = 0; be_last = 0;
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    for (int e = 0; e < 4; e++) begin
      ent_a = 1'b0;
      repeat ($urandom_range(1, 3)) tick();
      ent_a = 1'b1;
      for (int w = 0; w < 8; w++) begin
        tick();
        n_checks++;
        if (obs_all() !== exp_all()) $display("FAIL fill_model cyc=%0d got=%h required=%h", cyc, obs_all(), exp_all());
        else n_pass++;
        if (rj_a === 1'b1) rej_n++;
        if (e == 3 && be_a === 1'b1) be_last++;
      end
    end
    n_checks++;
    if (rej_n !== 1) $display("FAIL full_rechazo_pulses got=%0d required=1", rej_n); else n_pass++;
    n_checks++;
    if (be_last !== 0) $display("FAIL full_barrier got=%0d required=0", be_last); else n_pass++;
    n_checks++;
    if ({cnt_a, ll_a} !== {7'd3, 1'b1}) $display("FAIL full_count got=%0d lleno=%b required=3 lleno=1", cnt_a, ll_a);
    else n_pass++;
  endtask

  task automatic test_tie();
    int first_side, overlap, max_cnt;
    first_side = 0; overlap = 0; max_cnt = 0;
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    for (int e = 0; e < 3; e++) begin
      if (e < 2) ent_a = 1'b0; else sal_a = 1'b0;
      tick();
      ent_a = 1'b1; sal_a = 1'b1;
      repeat (8) tick();
    end
    ent_a = 1'b0; sal_a = 1'b0;
    for (int i = 0; i < 16; i++) begin
      tick();
      if (i == 2) begin ent_a = 1'b1; sal_a = 1'b1; end
      n_checks++;
      if (obs_all() !== exp_all()) $display("FAIL tie_model cyc=%0d got=%h required=%h", cyc, obs_all(), exp_all());
      else n_pass++;
      if (be_a === 1'b1 && bs_a === 1'b1) overlap++;
      if (first_side == 0 && be_a === 1'b1) first_side = 1;
      if (first_side == 0 && bs_a === 1'b1) first_side = 2;
      if (int'(cnt_a) > max_cnt) max_cnt = int'(cnt_a);
    end
    n_checks++;
    if (first_side !== 1) $display("FAIL tie_first_side got=%0d required=1", first_side); else n_pass++;
    n_checks++;
    if (overlap !== 0) $display("FAIL tie_overlap got=%0d required=0", overlap); else n_pass++;
    n_checks++;
    if (max_cnt !== 2 || cnt_a !== 7'd1) $display("FAIL tie_counts got=%0d,%0d required=2,1", max_cnt, cnt_a);
    else n_pass++;
  endtask

  task automatic test_empty_exit();
    int rej_n, bs_fall, be_rise, seen_bs;
    rej_n = 0; bs_fall = -1; be_rise = -1; seen_bs = 0;
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    sal_a = 1'b0; tick(); sal_a = 1'b1;
    repeat (6) begin
      tick();
      if (rj_a === 1'b1) rej_n++;
    end
    n_checks++;
    if ({rej_n[3:0], cnt_a, va_a, be_a, bs_a} !== {4'd1, 7'd0, 1'b1, 1'b0, 1'b0})
      $display("FAIL empty_refuse got=%0d cnt=%0d vacio=%b required=1 cnt=0 vacio=1", rej_n, cnt_a, va_a);
    else n_pass++;
    ent_a = 1'b0; tick(); ent_a = 1'b1;
    repeat (8) tick();
    sal_a = 1'b0; tick(); sal_a = 1'b1;
    for (int i = 0; i < 16; i++) begin
      tick();
      ent_a = 1'b1;
      n_checks++;
      if (obs_all() !== exp_all()) $display("FAIL empty_model cyc=%0d got=%h required=%h", cyc, obs_all(), exp_all());
      else n_pass++;
      if (bs_a === 1'b1 && seen_bs == 0) begin seen_bs = 1; ent_a = 1'b0; end
      if (seen_bs == 1 && bs_a === 1'b0 && bs_fall < 0) bs_fall = i;
      if (be_a === 1'b1 && be_rise < 0) be_rise = i;
    end
    n_checks++;
    if (be_rise - bs_fall !== 1 || bs_fall < 0)
      $display("FAIL empty_latched_entry got=%0d required=1", be_rise - bs_fall);
    else n_pass++;
    n_checks++;
    if (cnt_a !== 7'd1) $display("FAIL empty_final_count got=%0d required=1", cnt_a); else n_pass++;
  endtask

  task automatic test_bcd();
    int bv;
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    for (int e = 0; e < 11; e++) begin
      if (e < 10) ent_b = 1'b0; else sal_b = 1'b0;
      for (int w = 0; w < 8; w++) begin
        tick();
        ent_b = 1'b1; sal_b = 1'b1;
        bv = int'(ten_b) * 10 + int'(uni_b);
        n_checks++;
        if (bv !== int'(cnt_b) || obs_all() !== exp_all())
          $display("FAIL bcd_scoreboard cyc=%0d got=%0d/%h required=%0d/%h", cyc, bv, obs_all(), cnt_b, exp_all());
        else n_pass++;
      end
      if (e == 8) begin
        n_checks++;
        if ({ten_b, uni_b} !== 8'h09) $display("FAIL bcd_nine got=%h required=09", {ten_b, uni_b}); else n_pass++;
      end
      if (e == 9) begin
        n_checks++;
        if ({ten_b, uni_b} !== 8'h10) $display("FAIL bcd_carry got=%h required=10", {ten_b, uni_b}); else n_pass++;
      end
    end
    n_checks++;
    if ({cnt_b, ten_b, uni_b} !== {7'd9, 8'h09})
      $display("FAIL bcd_borrow got=%0d %h required=9 09", cnt_b, {ten_b, uni_b});
    else n_pass++;
  endtask

  task automatic test_reset_mid_window();
    int stray;
    stray = 0;
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    ent_a = 1'b0; tick(); ent_a = 1'b1;
    tick(); tick();
    n_checks++;
    if (be_a !== 1'b1) $display("FAIL midrst_window_open got=%b required=1", be_a); else n_pass++;
    ent_a = 1'b0; tick(); ent_a = 1'b1; rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    n_checks++;
    if ({be_a, cnt_a} !== {1'b0, 7'd0}) $display("FAIL midrst_close got=%b cnt=%0d required=0 cnt=0", be_a, cnt_a);
    else n_pass++;
    for (int i = 0; i < 12; i++) begin
      tick();
      n_checks++;
      if (obs_all() !== exp_all()) $display("FAIL midrst_model cyc=%0d got=%h required=%h", cyc, obs_all(), exp_all());
      else n_pass++;
      if (be_a === 1'b1 || bs_a === 1'b1 || rj_a === 1'b1 || cnt_a !== 7'd0) stray++;
    end
    n_checks++;
    if (stray !== 0) $display("FAIL midrst_stale_grant got=%0d required=0", stray); else n_pass++;
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 3) == 0) ent_a = ~ent_a;
      if ($urandom_range(0, 3) == 0) sal_a = ~sal_a;
      if ($urandom_range(0, 2) == 0) ent_b = ~ent_b;
      if ($urandom_range(0, 4) == 0) sal_b = ~sal_b;
      rst_n = ($urandom_range(0, 199) != 0);
      tick();
      n_checks++;
      if (obs_all() !== exp_all()) $display("FAIL random_model cyc=%0d got=%h required=%h", cyc, obs_all(), exp_all());
      else n_pass++;
    end
    rst_n = 1'b1; ent_a = 1'b1; sal_a = 1'b1; ent_b = 1'b1; sal_b = 1'b1;
  endtask

  initial begin
    test_reset();
    test_single_entry();
    test_fill_and_refuse();
    test_tie();
    test_empty_exit();
    test_bcd();
    test_reset_mid_window();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
